generador_banderas: RTL and testbench

//  Producer side of the alarm monitor's flag interface. Scans the temperature, current and smoke

---
 rtl/generador_banderas.sv | 177 +++++++++++++++++
 tb/tb_generador_banderas.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/generador_banderas.sv
// Sensor scanner for the alarm monitor: drives a shared ADC, applies hysteresis and N-scan
// confirmation per channel, and debounces the enable switch.
module generador_banderas #(
    parameter int W        = 10,
    parameter int TEMP_ON  = 700,
    parameter int TEMP_OFF = 650,
    parameter int CORR_ON  = 512,
    parameter int CORR_OFF = 480,
    parameter int HUMO_ON  = 300,
    parameter int HUMO_OFF = 250,
    parameter int N_CONF   = 3,
    parameter int TIMEOUT  = 255,
    parameter int SCAN_GAP = 1000,
    parameter int SW_DEB   = 50000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         sw_raw,
    input  logic [W-1:0] adc_data,
    input  logic         adc_done,
    output logic         adc_start,
    output logic [1:0]   adc_ch,
    output logic         interruptor,
    output logic         temp,
    output logic         corriente_25,
    output logic         humo,
    output logic [2:0]   sensor_err
);

    localparam int CW = $clog2(N_CONF + 1);
    localparam int GW = $clog2(SCAN_GAP + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int DW = $clog2(SW_DEB + 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_EVAL} state_t;

    state_t               state_q;
    logic [GW-1:0]        gap_q;
    logic [TW-1:0]        wt_q;
    logic [1:0]           ch_q;
    logic [W-1:0]         sample_q;
    logic                 adc_start_q;
    logic [2:0]           flag_q;
    logic [2:0]           err_q;
    logic [2:0][CW-1:0]   conf_q;

    logic                 sync1_q;
    logic                 sync_q;
    logic                 intr_q;
    logic [DW-1:0]        deb_q;

    logic [W-1:0]         on_thr;
    logic [W-1:0]         off_thr;
    logic                 cur_flag;
    logic                 cand;
    logic [CW-1:0]        conf_nx;

    always_comb begin
        on_thr  = W'(HUMO_ON);
        off_thr = W'(HUMO_OFF);
        case (ch_q)
            2'd0: begin
                on_thr  = W'(TEMP_ON);
                off_thr = W'(TEMP_OFF);
            end
            2'd1: begin
                on_thr  = W'(CORR_ON);
                off_thr = W'(CORR_OFF);
            end
            default: ;
        endcase
        cur_flag = flag_q[ch_q];
        // While latched high, only a sample at or below OFF proposes a drop.
        cand     = cur_flag ? (sample_q > off_thr) : (sample_q >= on_thr);
        conf_nx  = conf_q[ch_q] + 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            gap_q       <= '0;
            wt_q        <= '0;
            ch_q        <= '0;
            sample_q    <= '0;
            adc_start_q <= 1'b0;
            flag_q      <= '0;
            err_q       <= '0;
            conf_q      <= '0;
        end else begin
            adc_start_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (gap_q == GW'(SCAN_GAP - 1)) begin
                        gap_q       <= '0;
                        ch_q        <= '0;
                        state_q     <= S_START;
                        adc_start_q <= 1'b1;
                    end else begin
                        gap_q <= gap_q + 1'b1;
                    end
                end
                S_START: begin
                    wt_q    <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (adc_done) begin
                        sample_q <= adc_data;
                        state_q  <= S_EVAL;
                    end else if (wt_q == TW'(TIMEOUT - 1)) begin
                        err_q[ch_q]  <= 1'b1;
                        conf_q[ch_q] <= '0;
                        if (ch_q == 2'd2) begin
                            gap_q   <= '0;
                            state_q <= S_IDLE;
                        end else begin
                            ch_q        <= ch_q + 2'd1;
                            state_q     <= S_START;
                            adc_start_q <= 1'b1;
                        end
                    end else begin
                        wt_q <= wt_q + 1'b1;
                    end
                end
                S_EVAL: begin
                    err_q[ch_q] <= 1'b0;
                    if (cand == cur_flag) begin
                        conf_q[ch_q] <= '0;
                    end else if (conf_nx == CW'(N_CONF)) begin
                        flag_q[ch_q] <= ~cur_flag;
                        conf_q[ch_q] <= '0;
                    end else begin
                        conf_q[ch_q] <= conf_nx;
                    end
                    if (ch_q == 2'd2) begin
                        gap_q   <= '0;
                        state_q <= S_IDLE;
                    end else begin
                        ch_q        <= ch_q + 2'd1;
                        state_q     <= S_START;
                        adc_start_q <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync_q  <= 1'b0;
            intr_q  <= 1'b0;
            deb_q   <= '0;
        end else begin
            sync1_q <= sw_raw;
            sync_q  <= sync1_q;
            if (sync_q == intr_q) begin
                deb_q <= '0;
            end else if (deb_q == DW'(SW_DEB - 1)) begin
                intr_q <= sync_q;
                deb_q  <= '0;
            end else begin
                deb_q <= deb_q + 1'b1;
            end
        end
    end

    assign adc_start    = adc_start_q;
    assign adc_ch       = ch_q;
    assign interruptor  = intr_q;
    assign temp         = flag_q[0];
    assign corriente_25 = flag_q[1];
    assign humo         = flag_q[2];
    assign sensor_err   = err_q;

endmodule

// File: tb/tb_generador_banderas.sv
// Directed bench for generador_banderas: hysteresis/confirmation, timeouts, reset and debounce.
module tb_generador_banderas;

    localparam int TIMEOUT  = 255;
    localparam int SCAN_GAP = 20;
    localparam int SW_DEB   = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       sw_raw = 1'b0;
    logic [9:0] adc_data = '0;
    logic       adc_done = 1'b0;
    logic       adc_start;
    logic [1:0] adc_ch;
    logic       interruptor;
    logic       temp;
    logic       corriente_25;
    logic       humo;
    logic [2:0] sensor_err;

    int total = 0;
    int bad   = 0;

    generador_banderas #(
        .W(10),
        .N_CONF(3),
        .TIMEOUT(TIMEOUT),
        .SCAN_GAP(SCAN_GAP),
        .SW_DEB(SW_DEB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sw_raw(sw_raw),
        .adc_data(adc_data),
        .adc_done(adc_done),
        .adc_start(adc_start),
        .adc_ch(adc_ch),
        .interruptor(interruptor),
        .temp(temp),
        .corriente_25(corriente_25),
        .humo(humo),
        .sensor_err(sensor_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit exceeded");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_start(input logic [1:0] ch);
        int n;
        n = 0;
        while (adc_start !== 1'b1 && n < 2000) begin
            step();
            n++;
        end
        check("adc_start_seen", {31'd0, adc_start}, 32'd1);
        check("adc_ch_at_start", {30'd0, adc_ch}, {30'd0, ch});
    endtask

    // k >= 0: adc_done in WAIT cycle k; k < 0: no done, conversion times out.
    task automatic conv(input logic [1:0] ch, input logic [9:0] d, input int k);
        wait_start(ch);
        if (k >= 0) begin
            repeat (k + 1) step();
            check("adc_ch_wait", {30'd0, adc_ch}, {30'd0, ch});
            adc_data = d;
            adc_done = 1'b1;
            step();
            adc_done = 1'b0;
            adc_data = '0;
            check("adc_ch_eval", {30'd0, adc_ch}, {30'd0, ch});
            step();
        end else begin
            repeat (TIMEOUT) step();
            check("err_before_timeout", {31'd0, sensor_err[ch]}, 32'd0);
            step();
            check("err_at_timeout", {31'd0, sensor_err[ch]}, 32'd1);
        end
    endtask

    task automatic scan(input logic [9:0] t, input logic [9:0] c, input logic [9:0] h, input int k2);
        conv(2'd0, t, 2);
        conv(2'd1, c, 3);
        conv(2'd2, h, k2);
    endtask

    initial begin
        repeat (3) step();
        check("rst_adc_start", {31'd0, adc_start}, 32'd0);
        check("rst_adc_ch", {30'd0, adc_ch}, 32'd0);
        check("rst_flags", {29'd0, temp, corriente_25, humo}, 32'd0);
        check("rst_err", {29'd0, sensor_err}, 32'd0);
        check("rst_intr", {31'd0, interruptor}, 32'd0);
        rst = 1'b1;

        // Two high scans then a low one must not set temp; three in a row must.
        scan(10'd720, 10'd100, 10'd100, 1);
        check("t1_s1", {31'd0, temp}, 32'd0);
        scan(10'd720, 10'd100, 10'd100, 1);
        check("t1_s2", {31'd0, temp}, 32'd0);
        scan(10'd600, 10'd100, 10'd100, 1);
        check("t1_s3_low", {31'd0, temp}, 32'd0);
        scan(10'd720, 10'd100, 10'd100, 1);
        check("t1_s4", {31'd0, temp}, 32'd0);
        scan(10'd720, 10'd100, 10'd100, 1);
        check("t1_s5", {31'd0, temp}, 32'd0);
        scan(10'd720, 10'd100, 10'd100, 1);
        check("t1_set", {31'd0, temp}, 32'd1);

        // Inside the hysteresis band the flag holds; three samples below OFF clear it.
        for (int i = 0; i < 5; i++) begin
            scan(10'd670, 10'd100, 10'd100, 1);
            check("t2_band_hold", {31'd0, temp}, 32'd1);
        end
        scan(10'd640, 10'd100, 10'd100, 1);
        check("t2_low1", {31'd0, temp}, 32'd1);
        scan(10'd640, 10'd100, 10'd100, 1);
        check("t2_low2", {31'd0, temp}, 32'd1);
        scan(10'd640, 10'd100, 10'd100, 1);
        check("t2_clear", {31'd0, temp}, 32'd0);

        // Channel 1 timeout, then recovery.
        conv(2'd0, 10'd100, 2);
        conv(2'd1, 10'd100, -1);
        check("t3_err", {29'd0, sensor_err}, 32'b010);
        conv(2'd2, 10'd100, 1);
        check("t3_err_held", {29'd0, sensor_err}, 32'b010);
        conv(2'd0, 10'd100, 2);
        conv(2'd1, 10'd100, 0);
        check("t3_err_cleared", {29'd0, sensor_err}, 32'b000);
        conv(2'd2, 10'd100, 1);

        // Done on the last WAIT cycle is accepted; samples exactly at ON set every flag.
        for (int i = 0; i < 3; i++) begin
            scan(10'd700, 10'd512, 10'd300, TIMEOUT - 1);
            check("t4_err", {29'd0, sensor_err}, 32'd0);
            check("t4_flags", {29'd0, temp, corriente_25, humo}, (i == 2) ? 32'b111 : 32'b000);
        end

        // Asynchronous reset in the middle of WAIT.
        wait_start(2'd0);
        repeat (3) step();
        check("t6_pre_flags", {29'd0, temp, corriente_25, humo}, 32'b111);
        #2 rst = 1'b0;
        #1;
        check("t6_async_start", {31'd0, adc_start}, 32'd0);
        check("t6_async_flags", {29'd0, temp, corriente_25, humo}, 32'd0);
        check("t6_async_err", {29'd0, sensor_err}, 32'd0);
        check("t6_async_ch", {30'd0, adc_ch}, 32'd0);
        @(posedge clk);
        #3 rst = 1'b1;
        repeat (SCAN_GAP - 1) @(posedge clk);
        #1;
        check("t6_gap_early", {31'd0, adc_start}, 32'd0);
        step();
        check("t6_gap_start", {31'd0, adc_start}, 32'd1);
        check("t6_gap_ch", {30'd0, adc_ch}, 32'd0);

        // Switch bounce must not reach interruptor; a held level lands 2+SW_DEB cycles later.
        for (int i = 0; i < 6; i++) begin
            sw_raw = ~sw_raw;
            for (int j = 0; j < 5; j++) begin
                step();
                check("t5_bounce", {31'd0, interruptor}, 32'd0);
            end
        end
        sw_raw = 1'b1;
        repeat (SW_DEB + 1) step();
        check("t5_deb_early", {31'd0, interruptor}, 32'd0);
        step();
        check("t5_deb_set", {31'd0, interruptor}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
